// File: rtl/dm_arbiter_if.sv
// Two-requester memory bus plus the shared single-port RAM command/response lines.
// Pure wiring, so it adds no latency.
// No backpressure: a requester holds req until its ready pulse arrives.
interface dm_arbiter_if #(
  parameter int ADDR_W = 15
);
  // requester 0
  logic              m0_req;
  logic              m0_we;
  logic [31:0]       m0_addr;
  logic [31:0]       m0_wdata;
  logic [1:0]        m0_type;
  logic              m0_ready;
  // requester 1
  logic              m1_req;
  logic              m1_we;
  logic [31:0]       m1_addr;
  logic [31:0]       m1_wdata;
  logic [1:0]        m1_type;
  logic              m1_ready;
  // shared load result
  logic [31:0]       rdata;
  // RAM command / response
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  // arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_type,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_type,
    input  ram_rdata,
    output m0_ready, m1_ready, rdata,
    output ram_en, ram_we, ram_idx, ram_wdata
  );

  // requester / RAM-model side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_type,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_type,
    output ram_rdata,
    input  m0_ready, m1_ready, rdata,
    input  ram_en, ram_we, ram_idx, ram_wdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving two requesters access to one RAM; byte/half stores use read-modify-write.
// Latency from the IDLE sampling edge to ready: 2 cycles for word stores, 3 for loads and sub-word stores.
// No backpressure: one access in flight; the loser keeps req high and is granted after the next return to IDLE.
module dm_arbiter #(
  parameter int ADDR_W = 15
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RDV  = 3'd3,
    ACK  = 3'd4
  } state_e;

  // type encoding: 2 = byte, 3 = half, 0/1 = word, so bit 1 marks a sub-word access
  localparam logic [1:0] TYPE_BYTE = 2'd2;
  localparam logic [1:0] TYPE_HALF = 2'd3;

  state_e             state_q, state_d;
  logic               gnt_q, gnt_d;     // 0 = m0, 1 = m1
  logic               last_q, last_d;   // port granted most recently
  logic               we_q, we_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;   // only word index plus byte offset are kept
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         typ_q, typ_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               sel_port;
  logic               sel_we;
  logic [ADDR_W+1:0]  sel_addr;
  logic [31:0]        sel_wdata;
  logic [1:0]         sel_typ;
  logic [31:0]        merged;

  // Address bits above the RAM size are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.m0_addr[31:ADDR_W+2], bus.m1_addr[31:ADDR_W+2]};

  // Pick the port to grant: on a tie, the one that did not win last time.
  always_comb begin
    sel_port = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      sel_port = ~last_q;
    end
    sel_we    = sel_port ? bus.m1_we                  : bus.m0_we;
    sel_addr  = sel_port ? bus.m1_addr[ADDR_W+1:0]    : bus.m0_addr[ADDR_W+1:0];
    sel_wdata = sel_port ? bus.m1_wdata               : bus.m0_wdata;
    sel_typ   = sel_port ? bus.m1_type                : bus.m0_type;
  end

  // Fold the latched sub-word store data into the word just read from RAM.
  always_comb begin
    merged = bus.ram_rdata;
    if (typ_q == TYPE_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (typ_q == TYPE_HALF) begin
      if (addr_q[1]) begin
        merged[31:16] = wdata_q[15:0];
      end else begin
        merged[15:0]  = wdata_q[15:0];
      end
    end
  end

  // Next-state logic: requests are only looked at in IDLE, the rest is sequencing.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    typ_d   = typ_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          gnt_d   = sel_port;
          last_d  = sel_port;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          typ_d   = sel_typ;
          state_d = (sel_we && !sel_typ[1]) ? WR : RD;
        end
      end
      WR:  state_d = ACK;
      RD:  state_d = RDV;
      RDV: begin
        if (!we_q) begin
          rdata_d = bus.ram_rdata;
        end
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM command and completion pulses decoded from the current state.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_idx   = addr_q[ADDR_W+1:2];
    bus.ram_wdata = wdata_q;
    bus.m0_ready  = 1'b0;
    bus.m1_ready  = 1'b0;
    case (state_q)
      WR: begin
        bus.ram_en = 1'b1;
        bus.ram_we = 1'b1;
      end
      RD: begin
        bus.ram_en = 1'b1;
      end
      RDV: begin
        if (we_q) begin
          bus.ram_en    = 1'b1;
          bus.ram_we    = 1'b1;
          bus.ram_wdata = merged;
        end
      end
      ACK: begin
        bus.m0_ready = ~gnt_q;
        bus.m1_ready =  gnt_q;
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdata_q;
  assign busy      = (state_q != IDLE);

  // State and latched-request registers; reset makes m0 win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      typ_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      typ_q   <= typ_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: behavioural RAM, vector table, scoreboard of expected writes and completions.
// Expected values come from a shadow memory and a reference merge.
// Requesters hold req until their ready pulse, then drop it.
module tb_dm_arbiter;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic init_ram;

  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_W(AW)) bus();

  dm_arbiter #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  typ;
    logic        chk;
    logic [31:0] mem_exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } rd_t;

  logic [31:0] ram   [0:(1<<AW)-1];
  logic [31:0] model [0:(1<<AW)-1];
  wr_t         wr_q [$];
  rd_t         rd_q [$];
  wr_t         wr_e;
  rd_t         rd_e;
  logic [31:0] last_rd;
  int          n_pass  = 0;
  int          n_total = 0;
  vec_t        tbl [12];

  function automatic logic [31:0] pat(input int i);
    return (i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
  endfunction

  // Behavioural single-port RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 64; i++) ram[i] <= pat(i);
    end else if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_idx] <= bus.ram_wdata;
      else            bus.ram_rdata    <= ram[bus.ram_idx];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] off, input logic [1:0] typ);
    logic [31:0] r;
    r = old;
    if (typ == 2'd2) begin
      case (off)
        2'd0: r[7:0]   = wd[7:0];
        2'd1: r[15:8]  = wd[7:0];
        2'd2: r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (typ == 2'd3) begin
      if (off[1]) r[31:16] = wd[15:0];
      else        r[15:0]  = wd[15:0];
    end else begin
      r = wd;
    end
    return r;
  endfunction

  // Scoreboard monitor: every RAM write and every ready pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bus.ram_en && bus.ram_we) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ram_write: got idx %h data %h expected no write", bus.ram_idx, bus.ram_wdata);
      end else begin
        wr_e = wr_q.pop_front();
        check("ram_write_idx",  {17'b0, bus.ram_idx}, {17'b0, wr_e.idx});
        check("ram_write_data", bus.ram_wdata, wr_e.data);
      end
    end
    if (bus.m0_ready || bus.m1_ready) begin
      check("ready_onehot", {31'b0, bus.m0_ready & bus.m1_ready}, 32'd0);
      if (rd_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ready: got m0 %b m1 %b expected none", bus.m0_ready, bus.m1_ready);
      end else begin
        rd_e = rd_q.pop_front();
        check("ready_port", {31'b0, bus.m1_ready}, {31'b0, rd_e.port});
        check("rdata",      bus.rdata, rd_e.rdata);
      end
    end
  end

  task automatic drive(input logic p, input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] t);
    if (!p) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_type = t;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_type = t;
    end
  endtask

  task automatic expect_access(input logic p, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] t);
    logic [AW-1:0] idx;
    wr_t w;
    rd_t r;
    idx = a[AW+1:2];
    r.port = p;
    if (we) begin
      w.idx  = idx;
      w.data = merge_ref(model[idx], d, a[1:0], t);
      model[idx] = w.data;
      wr_q.push_back(w);
      r.rdata = last_rd;
    end else begin
      r.rdata = model[idx];
      last_rd = model[idx];
    end
    rd_q.push_back(r);
  endtask

  task automatic do_access(input vec_t v, input string name, input bit scramble);
    int   cyc;
    logic got;
    expect_access(v.port, v.we, v.addr, v.wdata, v.typ);
    @(posedge clk); #1;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.typ);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      cyc++;
      if (scramble && cyc == 1) begin
        #1 drive(v.port, 1'b1, ~v.we, v.addr ^ 32'h0000_0FF4, ~v.wdata, ~v.typ);
      end
      @(negedge clk);
      got = v.port ? bus.m1_ready : bus.m0_ready;
    end
    check({name, "_latency"}, cyc, v.lat);
    drive(v.port, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    if (v.chk) check({name, "_mem"}, ram[v.addr[AW+1:2]], v.mem_exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     {31'b0, busy},         32'd0);
    check("rst_m0_ready", {31'b0, bus.m0_ready}, 32'd0);
    check("rst_m1_ready", {31'b0, bus.m1_ready}, 32'd0);
    check("rst_ram_en",   {31'b0, bus.ram_en},   32'd0);
    check("rst_ram_we",   {31'b0, bus.ram_we},   32'd0);
    check("rst_rdata",    bus.rdata,             32'd0);
    reset   = 1'b1;
    last_rd = 32'd0;
  endtask

  initial begin
    int seen;
    int cyc;
    reset    = 1'b0;
    init_ram = 1'b1;
    for (int i = 0; i < (1 << AW); i++) model[i] = (i < 64) ? pat(i) : 32'd0;
    last_rd  = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    @(posedge clk); #1;
    init_ram = 1'b0;

    //          port  we    addr          wdata         typ   chk   mem_exp       lat
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd1, 1'b1, 32'hDEAD_BEEF, 2};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h1122_3344, 2'd0, 1'b1, 32'h1122_3344, 2};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_0012, 32'h0000_00AB, 2'd2, 1'b1, 32'h11AB_3344, 3};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h1122_3344, 2'd1, 1'b1, 32'h1122_3344, 2};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0000_CAFE, 2'd3, 1'b1, 32'hCAFE_3344, 3};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 2'd1, 1'b1, 32'hCAFE_3344, 3};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0021, 32'hFFFF_FF5A, 2'd2, 1'b1, 32'hADAD_5AAD, 3};
    tbl[7]  = '{1'b1, 1'b1, 32'h0000_0022, 32'h1234_BEEF, 2'd3, 1'b1, 32'hBEEF_5AAD, 3};
    tbl[8]  = '{1'b0, 1'b0, 32'hFFF8_0020, 32'h0000_0000, 2'd2, 1'b1, 32'hBEEF_5AAD, 3};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_0023, 32'h0000_0077, 2'd2, 1'b1, 32'h77EF_5AAD, 3};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'd1, 1'b1, 32'hA5A5_A5A5, 3};
    tbl[11] = '{1'b0, 1'b1, 32'hFFF8_0020, 32'h0BAD_F00D, 2'd1, 1'b1, 32'h0BAD_F00D, 2};

    do_reset();
    for (int i = 0; i < 12; i++) do_access(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // Request fields wiggle after the sampling edge; latched values must be used.
    do_access('{1'b0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 2'd1, 1'b1, 32'h5555_AAAA, 2}, "scramble_st", 1'b1);
    do_access('{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 2'd1, 1'b1, 32'h5555_AAAA, 3}, "scramble_ld", 1'b1);

    // Both ports load continuously after reset: grants alternate starting with m0.
    do_reset();
    for (int k = 0; k < 6; k++)
      expect_access(k[0], 1'b0, k[0] ? 32'h0000_0020 : 32'h0000_0000, 32'd0, 2'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 2'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 2'd1);
    seen = 0;
    cyc  = 0;
    while (seen < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.m0_ready || bus.m1_ready) seen++;
      if (seen == 6) begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
      end
    end
    check("rr_completions", seen, 6);
    check("rr_last_rdata", bus.rdata, 32'h0BAD_F00D);

    // Reset during RD of a byte store abandons it with no write and no ready.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0024, 32'h0000_003C, 2'd2);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("abort_busy",   {31'b0, busy},         32'd0);
    check("abort_ram_en", {31'b0, bus.ram_en},   32'd0);
    check("abort_ready",  {31'b0, bus.m1_ready}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    last_rd = 32'd0;
    check("abort_rdata", bus.rdata, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_mem", ram[9], 32'hACAC_ACAC);
    do_access('{1'b1, 1'b1, 32'h0000_0024, 32'h0000_003C, 2'd2, 1'b1, 32'hACAC_AC3C, 3}, "after_abort", 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wr_q_drained", wr_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
